// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Imported by uart_tx and by its integration wrapper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int W_DEF            = 8;
  localparam int FRAME_BITS       = W_DEF + 2;

  function automatic int frame_len(int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter that drains a byte FIFO.
// Pops on the last STOP cycle so queued frames run back to back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int W            = W_DEF
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_empty,
  input  logic [W-1:0] i_data,
  output logic         o_rd,
  output logic         o_tx,
  output logic         o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BI = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [BI-1:0]  bit_idx;
  logic [W-1:0]   shift;
  logic           tx_q;
  logic           busy_q;
  logic           last;

  assign last = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // FIFO head is only sampled when idle or on the final stop cycle
  assign o_rd = !i_reset && !i_empty &&
                ((state == IDLE) ||
                 ((state == STOP) && last));

  assign o_tx   = tx_q;
  assign o_busy = busy_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (o_rd) begin
      state    <= START;
      baud_cnt <= '0;
      shift    <= i_data;
      tx_q     <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
        end
        START: begin
          if (last) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (last) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == BI'(W - 1)) begin
              state   <= STOP;
              bit_idx <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BI'(1);
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (last) begin
            state    <= IDLE;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx with a behavioural FIFO.
// A line-level model predicts o_tx, o_busy and o_rd every cycle.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int W     = 8;
  localparam int FLEN  = frame_len(W) * CPB;
  localparam int DEPTH = 127;

  logic         clk;
  logic         i_reset;
  logic         i_empty;
  logic [W-1:0] i_data;
  logic         o_rd;
  logic         o_tx;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem [256];
  int           wp = 0;
  int           rp = 0;
  logic [W-1:0] exp_q [$];

  assign i_empty = (wp == rp);
  assign i_data  = mem[rp % 256];

  uart_tx #(.CLKS_PER_BIT(CPB), .W(W)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_empty (i_empty),
    .i_data  (i_data),
    .o_rd    (o_rd),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endfunction

  // Behavioural FIFO read side: the pop lands on the edge o_rd is high
  always @(posedge clk) begin
    if (o_rd && (wp != rp)) rp <= rp + 1;
  end

  // Line model: a frame is 10 bit levels of CPB cycles each
  initial begin : monitor
    bit           active;
    int           pos;
    logic [9:0]   bits;
    logic         exp_tx;
    logic         exp_busy;
    logic         exp_rd;
    active = 1'b0;
    pos    = 0;
    bits   = '1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_tx   = active ? bits[pos / CPB] : 1'b1;
      exp_busy = active;
      exp_rd   = !i_reset && !i_empty &&
                 (!active || pos == FLEN - 1);
      chk("o_tx", o_tx, exp_tx);
      chk("o_busy", o_busy, exp_busy);
      chk("o_rd", o_rd, exp_rd);
      if (i_reset) begin
        active = 1'b0;
      end else if (exp_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: pop from empty queue");
          bits = '1;
        end else begin
          bits = {1'b1, exp_q.pop_front(), 1'b0};
        end
        active = 1'b1;
        pos    = 0;
      end else if (active) begin
        pos++;
        if (pos == FLEN) active = 1'b0;
      end
    end
  end

  task automatic push(input logic [W-1:0] b);
    mem[wp % 256] = b;
    wp = wp + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(i_empty && !o_busy) && n < max);
    chk("idle_timeout", int'(n >= max), 0);
  endtask

  initial begin : stim
    logic [W-1:0] b;
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    // idle with empty FIFO
    repeat (200) @(posedge clk);
    #1;

    push(8'h55);
    wait_idle(200);

    push(8'hA3);
    push(8'h0F);
    wait_idle(300);

    // reset at frame cycle 15, FIFO non-empty during reset
    push(8'h00);
    repeat (16) @(posedge clk);
    #1 i_reset = 1'b1;
    push(8'h3C);
    repeat (4) @(posedge clk);
    #1 i_reset = 1'b0;
    wait_idle(200);

    // late arrival at frame cycle 20
    push(8'h96);
    repeat (21) @(posedge clk);
    #1 push(8'h69);
    wait_idle(300);

    // fill to full under reset, then drain
    i_reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b = W'($urandom);
      push(b);
    end
    @(posedge clk);
    #1 i_reset = 1'b0;
    wait_idle(DEPTH * FLEN + 200);

    // random pushes at random spacing
    for (int i = 0; i < 30; i++) begin
      b = W'($urandom);
      push(b);
      repeat ($urandom_range(0, 60)) @(posedge clk);
      #1;
    end
    wait_idle(40 * FLEN);

    repeat (5) @(posedge clk);
    chk("scoreboard_left", exp_q.size(), 0);
    chk("fifo_drained", wp - rp, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
